// File: rtl/seg_sndcmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : seg_sndcmd_tx
// Purpose  : Main-CPU sound command transmitter. Queues CPU writes to the
//            sound port in a small FIFO and replays each byte as a stable
//            sndno value followed by one sndstart pulse, with setup, hold
//            and spacing times suited to the sound board's edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module seg_sndcmd_tx #(
  parameter int DEPTH_LOG2 = 2,
  parameter int SETUP_CYC  = 6,
  parameter int HOLD_CYC   = 48,
  parameter int SPACING    = 4800
) (
  input  logic       clk48M,
  input  logic       reset_n,
  input  logic       cpu_wr_snd,
  input  logic [7:0] cpu_do,
  input  logic       clr_ovf,
  output logic [7:0] sndno,
  output logic       sndstart,
  output logic       busy,
  output logic       fifo_full,
  output logic       ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0] c_DEPTH      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]         c_SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0]         c_HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0]         c_SPACE_LAST = 16'(SPACING - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_SPACE = 2'd3;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_wr_q;
  logic                  r_ovf;
  logic [1:0]            r_state;
  logic [15:0]           r_cnt;
  logic [7:0]            r_sndno;
  logic                  r_sndstart;

  logic                  w_full;
  logic                  w_nonempty;
  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_push_ok;
  logic [7:0]            w_head;

  assign w_full     = (r_count == c_DEPTH);
  assign w_nonempty = (r_count != '0);
  // One push per CPU write cycle: only the first clock of a high level counts.
  assign w_push_req = cpu_wr_snd & ~r_wr_q;
  // The FSM takes the next byte from IDLE, or at the end of a SPACE slot.
  assign w_pop      = w_nonempty &
                      ((r_state == S_IDLE) ||
                       ((r_state == S_SPACE) && (r_cnt == c_SPACE_LAST)));
  // A simultaneous pop frees a slot, so a push into a full FIFO still fits.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_head     = r_mem[r_rptr];

  assign sndno     = r_sndno;
  assign sndstart  = r_sndstart;
  assign busy      = (r_state != S_IDLE) | w_nonempty;
  assign fifo_full = w_full;
  assign ovf       = r_ovf;

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk48M) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= cpu_do;
    end
  end

  // FIFO pointers, occupancy, write-edge detect and sticky overflow flag.
  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wr_q  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr_q <= cpu_wr_snd;
      if (w_push_ok) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write takes priority over a clear on the same clock.
      if (w_push_req && !w_push_ok) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Command sequencer: setup -> strobe high -> spacing, one byte per slot.
  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sndno    <= '0;
      r_sndstart <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sndno <= w_head;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_sndstart <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_HIGH: begin
          // Keep counting from the rise so SPACE measures rise-to-slot-end.
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == c_HOLD_LAST) begin
            r_sndstart <= 1'b0;
            r_state    <= S_SPACE;
          end
        end
        S_SPACE: begin
          if (r_cnt == c_SPACE_LAST) begin
            if (w_pop) begin
              r_sndno <= w_head;
              r_cnt   <= '0;
              r_state <= S_SETUP;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_sndstart <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_sndcmd_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_sndcmd_tx
// Purpose  : Directed self-checking bench for seg_sndcmd_tx (default
//            parameters). A negedge monitor logs every sndstart rise with
//            its byte, cycle, preceding sndno stability and high length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_sndcmd_tx;

  logic       clk48M = 1'b0;
  logic       reset_n;
  logic       cpu_wr_snd;
  logic [7:0] cpu_do;
  logic       clr_ovf;
  logic [7:0] sndno;
  logic       sndstart;
  logic       busy;
  logic       fifo_full;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Monitor log
  logic [7:0] rise_byte [64];
  int         rise_cyc  [64];
  int         stab      [64];
  int         hi_len    [64];
  int         n_rise = 0;
  int         n_fall = 0;
  int         hi_run = 0;
  int         last_chg = 0;
  logic       prev_st = 1'b0;
  logic [7:0] prev_no = 8'h00;

  seg_sndcmd_tx dut (
    .clk48M     (clk48M),
    .reset_n    (reset_n),
    .cpu_wr_snd (cpu_wr_snd),
    .cpu_do     (cpu_do),
    .clr_ovf    (clr_ovf),
    .sndno      (sndno),
    .sndstart   (sndstart),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .ovf        (ovf)
  );

  always #5 clk48M = ~clk48M;

  always @(posedge clk48M) cyc <= cyc + 1;

  always @(negedge clk48M) begin
    if (sndno !== prev_no) last_chg = cyc;
    if (sndstart && !prev_st && n_rise < 64) begin
      rise_byte[n_rise] = sndno;
      rise_cyc[n_rise]  = cyc;
      stab[n_rise]      = cyc - last_chg;
      n_rise++;
    end
    if (sndstart) begin
      hi_run++;
    end else if (prev_st) begin
      if (n_fall < 64) hi_len[n_fall] = hi_run;
      n_fall++;
      hi_run = 0;
    end
    prev_st = sndstart;
    prev_no = sndno;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk48M);
      #1;
    end
  endtask

  // Hold a write for len clocks; p is the clock that samples the push.
  task automatic send(input logic [7:0] b, input int len, output int p);
    cpu_do     = b;
    cpu_wr_snd = 1'b1;
    p          = cyc + 1;
    tick(len);
    cpu_wr_snd = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (busy === 1'b0) begin
        at = cyc;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_rise(input int target, input int max);
    for (int i = 0; i < max; i++) begin
      if (n_rise >= target) break;
      tick(1);
    end
    check("rise_seen", 32'(n_rise >= target), 32'd1);
  endtask

  int p, p1, p2, p3, at, k, r0;
  logic [7:0] exp_bytes [6];
  logic       drop_seen;

  initial begin
    reset_n    = 1'b0;
    cpu_wr_snd = 1'b0;
    cpu_do     = 8'h00;
    clr_ovf    = 1'b0;
    tick(3);
    check("rst_sndno",     32'(sndno),     32'h00);
    check("rst_sndstart",  32'(sndstart),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_fifo_full", 32'(fifo_full), 32'h0);
    check("rst_ovf",       32'(ovf),       32'h0);
    reset_n = 1'b1;
    tick(3);

    // ---- Single write 0x81 held 20 clocks ----
    cpu_do     = 8'h81;
    cpu_wr_snd = 1'b1;
    p          = cyc + 1;
    tick(2);
    check("t1_sndno_pop", 32'(sndno), 32'h81);
    check("t1_busy",      32'(busy),  32'h1);
    tick(18);
    cpu_wr_snd = 1'b0;
    wait_idle(6000, at);
    check("t1_idle_at",  32'(at),          32'(p + 4807));
    check("t1_nrise",    32'(n_rise),      32'd1);
    check("t1_rise_cyc", 32'(rise_cyc[0]), 32'(p + 7));
    check("t1_byte",     32'(rise_byte[0]), 32'h81);
    check("t1_hi_len",   32'(hi_len[0]),   32'd48);
    check("t1_stab",     32'(stab[0]),     32'd6);

    // ---- Three writes within 100 clocks ----
    tick(5);
    send(8'h10, 5, p1);
    tick(20);
    send(8'h20, 5, p2);
    tick(20);
    send(8'h30, 5, p3);
    wait_idle(16000, at);
    check("t2_idle",     32'(at >= 0),     32'd1);
    check("t2_nrise",    32'(n_rise),      32'd4);
    check("t2_rise0",    32'(rise_cyc[1]), 32'(p1 + 7));
    check("t2_byte0",    32'(rise_byte[1]), 32'h10);
    check("t2_byte1",    32'(rise_byte[2]), 32'h20);
    check("t2_byte2",    32'(rise_byte[3]), 32'h30);
    check("t2_period01", 32'(rise_cyc[2] - rise_cyc[1]), 32'd4806);
    check("t2_period12", 32'(rise_cyc[3] - rise_cyc[2]), 32'd4806);
    for (int i = 1; i < 4; i++) begin
      check("t2_stab",   32'(stab[i]),   32'd6);
      check("t2_hi_len", 32'(hi_len[i]), 32'd48);
    end

    // ---- Overflow, clear, push on the pop clock while full ----
    tick(5);
    k = n_rise;
    send(8'hA0, 3, p);
    tick(10);
    send(8'hA1, 3, p);
    tick(3);
    send(8'hA2, 3, p);
    tick(3);
    send(8'hA3, 3, p);
    tick(3);
    check("t3_not_full", 32'(fifo_full), 32'h0);
    send(8'hA4, 3, p);
    check("t3_full",     32'(fifo_full), 32'h1);
    check("t3_ovf_pre",  32'(ovf),       32'h0);
    tick(3);
    send(8'h55, 3, p);
    check("t3_ovf_set",  32'(ovf),       32'h1);
    check("t3_full2",    32'(fifo_full), 32'h1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("t3_ovf_clr",  32'(ovf),       32'h0);
    wait_rise(k + 1, 100);
    r0 = rise_cyc[k];
    while (cyc < r0 + 4799) tick(1);
    cpu_do     = 8'hA5;
    cpu_wr_snd = 1'b1;
    tick(1);
    check("t3_popcyc",      32'(cyc),       32'(r0 + 4800));
    check("t3_pp_full",     32'(fifo_full), 32'h1);
    check("t3_pp_ovf",      32'(ovf),       32'h0);
    check("t3_pp_sndno",    32'(sndno),     32'hA1);
    tick(2);
    cpu_wr_snd = 1'b0;
    tick(2);
    // Dropped write and clear on the same clock: the set must win.
    cpu_do     = 8'h66;
    cpu_wr_snd = 1'b1;
    clr_ovf    = 1'b1;
    tick(1);
    clr_ovf    = 1'b0;
    check("t3_set_wins", 32'(ovf), 32'h1);
    tick(2);
    cpu_wr_snd = 1'b0;
    clr_ovf    = 1'b1;
    tick(1);
    clr_ovf    = 1'b0;
    check("t3_ovf_clr2", 32'(ovf), 32'h0);
    wait_idle(30000, at);
    check("t3_idle",  32'(at >= 0), 32'd1);
    check("t3_nrise", 32'(n_rise),  32'(k + 6));
    exp_bytes[0] = 8'hA0; exp_bytes[1] = 8'hA1; exp_bytes[2] = 8'hA2;
    exp_bytes[3] = 8'hA3; exp_bytes[4] = 8'hA4; exp_bytes[5] = 8'hA5;
    drop_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t3_byte", 32'(rise_byte[k + i]), 32'(exp_bytes[i]));
      if (rise_byte[k + i] == 8'h55 || rise_byte[k + i] == 8'h66) drop_seen = 1'b1;
    end
    check("t3_dropped_never_sent", 32'(drop_seen), 32'h0);

    // ---- Reset during HIGH with a byte still queued ----
    tick(5);
    k = n_rise;
    send(8'h77, 3, p);
    tick(2);
    send(8'h78, 3, p);
    wait_rise(k + 1, 50);
    tick(5);
    check("t4_high", 32'(sndstart), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t4_rst_sndstart", 32'(sndstart), 32'h0);
    check("t4_rst_sndno",    32'(sndno),    32'h00);
    check("t4_rst_busy",     32'(busy),     32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(100);
    check("t4_no_strobe", 32'(n_rise), 32'(k + 1));
    check("t4_busy",      32'(busy),   32'h0);
    check("t4_sndno",     32'(sndno),  32'h00);

    // ---- Write held for 10000 clocks ----
    k = n_rise;
    send(8'h99, 10000, p);
    wait_idle(6000, at);
    check("t5_idle",     32'(at >= 0),     32'd1);
    check("t5_nrise",    32'(n_rise),      32'(k + 1));
    check("t5_byte",     32'(rise_byte[k]), 32'h99);
    check("t5_rise_cyc", 32'(rise_cyc[k]), 32'(p + 7));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_sndcmd_tx.md
Name: seg_sndcmd_tx

Overview:
- Main-CPU-side sound command transmitter. It is the sending end of the sndno/sndstart interface that the sound subsystem samples.
- It captures main-CPU writes to the sound command port into a small FIFO. It then replays each command as a stable sndno byte plus a single sndstart rising edge.
- Setup, hold and spacing times are chosen so the sound board's 8 MHz edge detector sees every command. They also give the sound Z80's NMI handler time to read its command latch before it is overwritten.

Parameters:
- DEPTH_LOG2, 2, FIFO depth is 2**DEPTH_LOG2 entries (default 4).
- SETUP_CYC, 6, clk48M cycles that sndno is stable before sndstart rises (must be >=1).
- HOLD_CYC, 48, clk48M cycles that sndstart stays high (must be >=12, i.e. at least two 8 MHz periods).
- SPACING, 4800, minimum clk48M cycles from one sndstart rise to the end of that command slot (must be > HOLD_CYC, and <65536).

Ports:
- clk48M  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_wr_snd  in  1  level: main CPU write cycle to the sound port is active. It may stay high for many clocks.
- cpu_do  in  8  main CPU write data, valid while cpu_wr_snd is high.
- clr_ovf  in  1  synchronous clear of the ovf flag.
- sndno  out  8  command byte delivered to the sound board.
- sndstart  out  1  command strobe; the receiver acts on its rising edge.
- busy  out  1  high whenever the FSM is not IDLE or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- ovf  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n low, asynchronous): sndno=0, sndstart=0, FIFO empty, FSM=IDLE, counters=0, ovf=0, busy=0, fifo_full=0, write-edge register=0. Asserting reset mid-command drops sndstart immediately.
- Write capture: register wr_q <= cpu_wr_snd every clock.
  - A push request occurs on a clock where cpu_wr_snd=1 and wr_q=0. Exactly one push happens per write cycle, whatever its length.
  - cpu_do is taken on that clock.
- Push acceptance: a push is accepted if the FIFO is not full, or if a pop occurs on the same clock.
  - Otherwise the byte is discarded and ovf<=1.
  - If a dropped push and clr_ovf occur together, the set wins.
- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits that wrap modulo the depth, plus a count of DEPTH_LOG2+1 bits.
  - Push and pop on the same clock leave the count unchanged.
  - fifo_full = (count == 2**DEPTH_LOG2).
- FSM, with a 16-bit counter cnt:
  - IDLE: if count>0, pop the head into sndno, set cnt=0 and go to SETUP. sndstart=0.
    - A push into an empty FIFO is not visible to IDLE until the next clock.
  - SETUP: cnt increments each clock. When cnt==SETUP_CYC-1, set sndstart<=1, cnt<=0 and go to HIGH.
  - HIGH: sndstart=1. When cnt==HOLD_CYC-1, set sndstart<=0 and go to SPACE. cnt continues counting from the rise and is not reset.
  - SPACE: sndstart=0. When cnt==SPACING-1, do the following:
    - If count>0, pop the next byte into sndno, set cnt=0 and go to SETUP.
    - Otherwise go to IDLE.
- Timing that follows from the FSM:
  - sndstart rises SETUP_CYC+1 clocks after the push clock when the FSM is IDLE and the FIFO was empty.
  - It stays high exactly HOLD_CYC clocks.
  - For back-to-back commands the rise-to-rise period is SPACING+SETUP_CYC.
- sndno changes only on a pop. Between commands and in IDLE it holds the last value sent.
- Commands are never merged or reordered. Two writes of the same byte produce two strobes.

Test Plan:
- Single write of 0x81 (cpu_wr_snd high for 20 clocks) with defaults -> sndno=0x81 one clock after the push. sndstart rises 7 clocks after the push and is high for exactly 48 clocks. Exactly one strobe. busy returns to 0 after 4800+6 clocks from the pop.
- Three writes 0x10, 0x20, 0x30 within 100 clocks -> three rises in that order, 4806 clocks apart. sndno is stable from 6 clocks before each rise until the next pop.
- Five writes while the FSM is busy with DEPTH_LOG2=2 -> the fourth write fills the FIFO and the fifth (0x55) is dropped: ovf=1 and 0x55 is never output. clr_ovf pulse -> ovf=0.
- Push on the exact clock SPACE pops while the FIFO is full -> the push is accepted, fifo_full stays 1, and ovf stays 0.
- reset_n low during HIGH -> sndstart=0 and sndno=0 with no clock edge. After release, the FIFO is empty and no strobe occurs.
- A write held high for 10000 clocks -> exactly one strobe is produced.
